detector_scheduler: RTL and testbench
=====================================

# detector_scheduler

Round-robin scheduler that shares one serial pattern detector among `N_REQ` word-parallel requesters. A granted requester's word is parked, the detector is cleared, and the word is streamed MSB-first through it. The detector's sticky match flag is then sampled and returned to the requester with its ID. The block sits between the requesting datapath blocks and a single instance of the team's serial detector (`CLK`/`RESET`/`INP`/`OUT` ports, active-high async reset, sticky `OUT`).

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `WORD_W`, default 8: bits per word streamed to the detector, ≥ 2.
- `ID_W`, default `$clog2(N_REQ)`: width of the returned requester ID.

- `CLK`  in  1  single clock; all logic on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `REQ`  in  `N_REQ`  per-requester request level; held until `GNT`.
- `DATA`  in  `N_REQ*WORD_W`  packed words, requester *i* at `[i*WORD_W +: WORD_W]`; valid while its `REQ` is high.
- `GNT`  out  `N_REQ`  one-hot, one-cycle grant pulse.
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle result strobe.
- `DONE_ID`  out  `ID_W`  requester index for the current `DONE`.
- `MATCH`  out  1  detector result, valid with `DONE`.
- `DET_RESET`  out  1  drives the detector `RESET` (active-high).
- `DET_INP`  out  1  drives the detector `INP`.
- `DET_OUT`  in  1  detector `OUT` (registered, sticky until `DET_RESET`).

## Operation
- Reset values:
  - `GNT`, `BUSY`, `DONE`, `DONE_ID`, `MATCH`, `DET_INP` are 0.
  - `DET_RESET` is 1.
  - Round-robin pointer is 0; state is IDLE.
- **IDLE**: `DET_RESET` = 1. If `REQ` ≠ 0:
  - Pick the winner by round robin, starting from the pointer.
  - Latch the winner's `DATA` word and its ID.
  - Set the pointer to winner+1, wrapping from `N_REQ`-1 to 0.
  - Go to CLEAR.
- **CLEAR**: 1 cycle. `GNT[id]` = 1, `DET_RESET` = 1, `BUSY` = 1. Go to SHIFT with bit counter = 0.
- **SHIFT**: `WORD_W` cycles.
  - `DET_RESET` = 0.
  - `DET_INP` = `word[WORD_W-1-cnt]`.
  - Counter increments each cycle; after cnt = `WORD_W`-1, go to SAMPLE.
- **SAMPLE**: 1 cycle. `DET_RESET` = 0. Capture `DET_OUT` into the match register.
- **REPORT**: 1 cycle. `DONE` = 1, `DONE_ID` = id, `MATCH` = captured value, `DET_RESET` = 1. Go to IDLE.
- Outside IDLE, `REQ` and `DATA` are ignored. The latched word is used, so a requester may change `DATA` after `GNT`.
- `DET_INP` is 0 in every state except SHIFT. `DONE_ID` and `MATCH` return to 0 when `DONE` is low.
- A requester that is still requesting after its `DONE` is treated as a new request and arbitrated normally.
- Reset mid-frame: all outputs go to their reset values asynchronously, including `DET_RESET` = 1, which clears the detector. The in-flight frame is dropped and no `DONE` is issued.

## Timing
- Accept edge: the end of an IDLE cycle with `REQ` ≠ 0, called cycle 0.
- Cycle 1: `GNT` pulse.
- Cycles 2..`WORD_W`+1: bits on `DET_INP`; the detector samples each bit at the end of its cycle.
- Cycle `WORD_W`+2: SAMPLE.
- Cycle `WORD_W`+3: `DONE`.
- Next arbitration in cycle `WORD_W`+4, giving a throughput of one frame per `WORD_W`+4 cycles.
- `GNT` precedes `DONE` by exactly `WORD_W`+2 cycles.
- `DET_RESET` is high for at least the CLEAR cycle before the first bit.
- Round-robin fairness: with all `REQ` high continuously, grants cycle 0,1,…,`N_REQ`-1,0,…; no requester waits more than `N_REQ`-1 frames.

## Structure
- Package `detector_scheduler_pkg`:
  - State enum `sched_state_t` (IDLE, CLEAR, SHIFT, SAMPLE, REPORT).
  - Constants `SCHED_FRAME_CYCLES` = `WORD_W`+4 and `SCHED_FIRST_BIT_CYC` = 2.
- Sub-module `rr_arbiter`:
  - Inputs: `REQ`, pointer. Outputs: one-hot winner, winner index. Combinational.
  - Reusable by other shared-resource controllers.

## Test plan
Each scenario pairs the block with the team's serial detector. `WORD_W` = 8, `N_REQ` = 4.
- Reset release, idle: with `REQ` = 0 for 20 cycles → `DET_RESET` = 1, `BUSY` = 0, no `GNT`/`DONE`.
- Single request, `REQ` = 4'b0010, word 8'b0101_0000:
  - `GNT` = 4'b0010 in cycle 1.
  - `DET_INP` = 0,1,0,1,0,0,0,0 in cycles 2..9.
  - `DONE` in cycle 11 with `DONE_ID` = 1, `MATCH` = 1.
- No-match words: 8'hFF → `MATCH` = 0; 8'b1010_0000 → `MATCH` = 1; 8'h01 → `MATCH` = 0.
- Round robin under full load: `REQ` = 4'b1111 held → `DONE_ID` sequence 0,1,2,3,0 with `DONE` strobes exactly 12 cycles apart.
- Data changed after grant: `DATA` altered in the cycle after `GNT` → streamed bits still equal the word latched at the accept edge.
- Reset mid-SHIFT: `RESET_N` low during bit 4 →
  - Outputs reset immediately and `DET_RESET` = 1.
  - After release, a new request completes normally.
  - No `DONE` is issued for the aborted frame.

Source files
------------

// File: rtl/detector_scheduler_pkg.sv
// rtl/detector_scheduler_pkg.sv - shared types and frame timing constants for detector_scheduler
package detector_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        SAMPLE = 3'd3,
        REPORT = 3'd4
    } sched_state_t;

    localparam int SCHED_WORD_W        = 8;
    localparam int SCHED_FRAME_CYCLES  = SCHED_WORD_W + 4;
    localparam int SCHED_FIRST_BIT_CYC = 2;

    // Accept, clear, WORD_W shift cycles, sample and report.
    function automatic int sched_frame_cycles(input int word_w);
        return word_w + 4;
    endfunction

endpackage

// File: rtl/detector_scheduler_rr_arbiter.sv
// rtl/detector_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr_i
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    always_comb begin
        int c;
        c       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/detector_scheduler.sv
// rtl/detector_scheduler.sv - shares one serial pattern detector among N_REQ word requesters
module detector_scheduler
    import detector_scheduler_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ*WORD_W-1:0] DATA,
    output logic [N_REQ-1:0]        GNT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [ID_W-1:0]         DONE_ID,
    output logic                    MATCH,
    output logic                    DET_RESET,
    output logic                    DET_INP,
    input  logic                    DET_OUT
);

    localparam int CNT_W = $clog2(WORD_W);

    sched_state_t      state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_d;
    logic [ID_W-1:0]   id_q;
    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_REQ-1:0]  gnt_q;
    logic              busy_q;
    logic              done_q;
    logic [ID_W-1:0]   done_id_q;
    logic              match_q;
    logic              det_reset_q;
    logic              det_inp_q;

    logic [N_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_valid;
    logic [WORD_W-1:0] word_sel;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        word_sel = DATA[int'(arb_idx)*WORD_W +: WORD_W];
        ptr_d    = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end

    // The word is parked in a shift register so DATA may change after the grant.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_q     <= 1'b0;
            det_reset_q <= 1'b1;
            det_inp_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    det_reset_q <= 1'b1;
                    if (arb_valid) begin
                        state_q <= CLEAR;
                        gnt_q   <= arb_gnt;
                        busy_q  <= 1'b1;
                        shift_q <= word_sel;
                        id_q    <= arb_idx;
                        ptr_q   <= ptr_d;
                    end
                end
                CLEAR: begin
                    state_q     <= SHIFT;
                    gnt_q       <= '0;
                    det_reset_q <= 1'b0;
                    det_inp_q   <= shift_q[WORD_W-1];
                    shift_q     <= shift_q << 1;
                    cnt_q       <= '0;
                end
                SHIFT: begin
                    if (cnt_q == CNT_W'(WORD_W - 1)) begin
                        state_q   <= SAMPLE;
                        det_inp_q <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        det_inp_q <= shift_q[WORD_W-1];
                        shift_q   <= shift_q << 1;
                    end
                end
                SAMPLE: begin
                    // DET_OUT already reflects the last bit, which the detector took at the previous edge.
                    state_q     <= REPORT;
                    match_q     <= DET_OUT;
                    done_q      <= 1'b1;
                    done_id_q   <= id_q;
                    det_reset_q <= 1'b1;
                end
                REPORT: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    done_id_q <= '0;
                    match_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    det_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign GNT       = gnt_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DONE_ID   = done_id_q;
    assign MATCH     = match_q;
    assign DET_RESET = det_reset_q;
    assign DET_INP   = det_inp_q;

endmodule

// File: tb/tb_detector_scheduler.sv
// tb/tb_detector_scheduler.sv - self-checking bench for detector_scheduler with a "101" sticky detector
module tb_detector_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic [N-1:0]  REQ = '0;
    logic [N*W-1:0] DATA = '0;
    logic [N-1:0]  GNT;
    logic          BUSY, DONE, MATCH, DET_RESET, DET_INP;
    logic [IW-1:0] DONE_ID;
    logic          DET_OUT = 1'b0;
    logic [1:0]    det_hist = 2'b00;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    int gnt_cyc[$];
    int gnt_val[$];
    int done_cyc[$];
    int done_idv[$];
    int done_mat[$];
    logic inp_hist [0:1023];

    detector_scheduler #(.N_REQ(N), .WORD_W(W), .ID_W(IW)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .REQ       (REQ),
        .DATA      (DATA),
        .GNT       (GNT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DONE_ID   (DONE_ID),
        .MATCH     (MATCH),
        .DET_RESET (DET_RESET),
        .DET_INP   (DET_INP),
        .DET_OUT   (DET_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Serial detector: sticky flag once "101" has been seen since the last reset.
    always @(posedge CLK or posedge DET_RESET) begin
        if (DET_RESET) begin
            det_hist <= 2'b00;
            DET_OUT  <= 1'b0;
        end else begin
            if ({det_hist, DET_INP} == 3'b101) DET_OUT <= 1'b1;
            det_hist <= {det_hist[0], DET_INP};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit has101(input logic [W-1:0] w);
        logic [W-1:0] t;
        for (int i = 0; i <= W - 3; i++) begin
            t = w >> i;
            if (t[2:0] == 3'b101) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Frame-level model: everything follows from the cycle offset since the accept edge.
    bit           m_active = 1'b0;
    int           m_off = 0;
    int           m_id = 0;
    int           m_ptr = 0;
    logic [W-1:0] m_word = '0;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_active = 1'b0;
            m_off    = 0;
            m_id     = 0;
            m_ptr    = 0;
        end else if (m_active) begin
            m_off++;
            if (m_off == W + 4) m_active = 1'b0;
        end else if (REQ != '0) begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && REQ[c]) begin
                    found = 1'b1;
                    m_id  = c;
                end
            end
            m_word   = DATA[m_id*W +: W];
            m_ptr    = (m_id + 1) % N;
            m_active = 1'b1;
            m_off    = 1;
        end
    end

    always @(negedge CLK) begin
        logic [N-1:0] e_gnt;
        logic e_busy, e_done, e_match, e_rst, e_inp;
        int e_id;
        e_busy  = m_active;
        e_gnt   = (m_active && m_off == 1) ? N'(1 << m_id) : '0;
        e_rst   = !(m_active && m_off >= 2 && m_off <= W + 2);
        e_inp   = (m_active && m_off >= 2 && m_off <= W + 1) ? m_word[W - 1 - (m_off - 2)] : 1'b0;
        e_done  = m_active && m_off == W + 3;
        e_id    = e_done ? m_id : 0;
        e_match = e_done ? has101(m_word) : 1'b0;
        check("gnt", 32'(GNT), 32'(e_gnt));
        check("busy", 32'(BUSY), 32'(e_busy));
        check("det_reset", 32'(DET_RESET), 32'(e_rst));
        check("det_inp", 32'(DET_INP), 32'(e_inp));
        check("done", 32'(DONE), 32'(e_done));
        check("done_id", 32'(DONE_ID), 32'(e_id));
        check("match", 32'(MATCH), 32'(e_match));
        if (cyc < 1024) inp_hist[cyc] = DET_INP;
        if (GNT != '0) begin
            gnt_cyc.push_back(cyc);
            gnt_val.push_back(int'(GNT));
        end
        if (DONE) begin
            done_cyc.push_back(cyc);
            done_idv.push_back(int'(DONE_ID));
            done_mat.push_back(int'(MATCH));
        end
    end

    task automatic clear_logs();
        gnt_cyc.delete();
        gnt_val.delete();
        done_cyc.delete();
        done_idv.delete();
        done_mat.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic run_single(input int id, input logic [W-1:0] w, input bit alter, output int k);
        clear_logs();
        tick(1);
        DATA[id*W +: W] = w;
        REQ = N'(1 << id);
        k = cyc;
        tick(2);
        REQ = '0;
        if (alter) DATA[id*W +: W] = ~w;
        tick(12);
    endtask

    task automatic check_frame(input string tag, input int k, input int id,
                               input logic [W-1:0] w, input int exp_match);
        check({tag, "_ngnt"}, 32'(gnt_cyc.size()), 32'd1);
        check({tag, "_ndone"}, 32'(done_cyc.size()), 32'd1);
        if (gnt_cyc.size() == 1) begin
            check({tag, "_gnt_cyc"}, 32'(gnt_cyc[0] - k), 32'd1);
            check({tag, "_gnt_val"}, 32'(gnt_val[0]), 32'(1 << id));
        end
        if (done_cyc.size() == 1) begin
            check({tag, "_done_cyc"}, 32'(done_cyc[0] - k), 32'd11);
            check({tag, "_done_id"}, 32'(done_idv[0]), 32'(id));
            check({tag, "_match"}, 32'(done_mat[0]), 32'(exp_match));
        end
        for (int i = 0; i < W; i++) begin
            check({tag, "_bit"}, 32'(inp_hist[k + 2 + i]), 32'(w[W - 1 - i]));
        end
    endtask

    initial begin
        int k;
        tick(3);
        RESET_N = 1'b1;

        clear_logs();
        tick(20);
        check("idle_ngnt", 32'(gnt_cyc.size()), 32'd0);
        check("idle_ndone", 32'(done_cyc.size()), 32'd0);
        check("idle_det_reset", 32'(DET_RESET), 32'd1);
        check("idle_busy", 32'(BUSY), 32'd0);

        run_single(1, 8'b0101_0000, 1'b0, k);
        check_frame("single", k, 1, 8'b0101_0000, 1);

        run_single(2, 8'hFF, 1'b0, k);
        check_frame("w_ff", k, 2, 8'hFF, 0);
        run_single(3, 8'b1010_0000, 1'b0, k);
        check_frame("w_a0", k, 3, 8'b1010_0000, 1);
        run_single(0, 8'h01, 1'b0, k);
        check_frame("w_01", k, 0, 8'h01, 0);

        run_single(2, 8'b1011_0011, 1'b1, k);
        check_frame("latched", k, 2, 8'b1011_0011, 1);

        RESET_N = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        clear_logs();
        tick(1);
        REQ = '1;
        DATA = {8'h05, 8'h0A, 8'h14, 8'hFF};
        k = cyc;
        tick(49);
        REQ = '0;
        tick(15);
        check("rr_ndone", 32'(done_cyc.size()), 32'd5);
        check("rr_ngnt", 32'(gnt_cyc.size()), 32'd5);
        for (int j = 0; j < 5 && j < done_cyc.size() && j < gnt_cyc.size(); j++) begin
            check("rr_done_id", 32'(done_idv[j]), 32'(j % 4));
            check("rr_done_cyc", 32'(done_cyc[j] - k), 32'(11 + 12 * j));
            check("rr_gnt_val", 32'(gnt_val[j]), 32'(1 << (j % 4)));
        end

        clear_logs();
        tick(1);
        DATA[3*W +: W] = 8'b0101_0101;
        REQ = 4'b1000;
        k = cyc;
        tick(2);
        REQ = '0;
        tick(4);
        #1;
        check("pre_rst_busy", 32'(BUSY), 32'd1);
        check("pre_rst_det_reset", 32'(DET_RESET), 32'd0);
        RESET_N = 1'b0;
        #1;
        check("rst_det_reset", 32'(DET_RESET), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_det_inp", 32'(DET_INP), 32'd0);
        check("rst_gnt", 32'(GNT), 32'd0);
        tick(2);
        RESET_N = 1'b1;
        tick(15);
        check("abort_ndone", 32'(done_cyc.size()), 32'd0);
        run_single(0, 8'b0000_0101, 1'b0, k);
        check_frame("post_rst", k, 0, 8'b0000_0101, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
